seq_mux_scanner: RTL and testbench
==================================

# seq_mux_scanner

Parametrised, registered N-input multiplexer with an auto-scanning channel sequencer and a valid/ready output stage. It generalises the dual 4-to-1 selector parts of the 74xxx library to arbitrary word width and input count. It adds a scan mode that walks the inputs in order, for round-robin sampling of register banks and status lines into a single downstream consumer.

## Interface
Parameters:
- `WIDTH`, default 8: bits per input word and output word.
- `INPUTS`, default 4: number of inputs; power of two, at least 2.
- `SEL_W`, default 2: select width; must equal log2(`INPUTS`).

Ports:
- `clock`  in  1  — single clock; all state changes on the rising edge.
- `notReset`  in  1  — asynchronous, active-low reset.
- `notEnable`  in  1  — active-low enable; while high, no captures occur and pointer state holds.
- `mode`  in  1  — 0 = manual (`sel` chooses the channel), 1 = scan (internal pointer chooses the channel).
- `sel`  in  SEL_W  — manual channel index.
- `in`  in  INPUTS*WIDTH  — packed inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- `mask`  in  INPUTS  — scan channel mask, 1 = channel included. The port is always present and is used only with the macro in Configuration.
- `out`  out  WIDTH  — registered sample.
- `outChannel`  out  SEL_W  — channel index of `out`.
- `outValid`  out  1  — `out`/`outChannel`/`outWrap` hold a sample not yet accepted.
- `outReady`  in  1  — consumer accepts the sample on an edge with `outValid`=1.
- `outWrap`  out  1  — qualifies the sample: it is the last sample of a scan pass.

## Operation
- Capture condition per edge: `notEnable`=0, a channel is available, and (`outValid`=0 or `outReady`=1).
- Channel selection:
  - Manual mode uses `sel`.
  - Scan mode uses the internal pointer `scanPtr` (SEL_W bits).
- On capture:
  - `out` <= selected input word.
  - `outChannel` <= channel index.
  - `outValid` <= 1.
  - `outWrap` <= 1 only in scan mode when the next pointer value is numerically ≤ the captured channel; otherwise 0.
- No capture and `outValid`=1 and `outReady`=1: `outValid` <= 0. `out`, `outChannel` and `outWrap` hold their values.
- No capture and no acceptance: all output registers hold.
- Scan pointer:
  - After each scan-mode capture it advances to the next channel, modulo `INPUTS`; (`INPUTS`-1)+1 wraps to 0.
  - It holds in manual mode and when no capture occurs.
- Mode switch takes effect on the next capture; the sample already in the output register is unaffected.
- `notEnable` high does not clear `outValid`; a pending sample can still be accepted.
- Manual mode ignores `mask`.

## Timing
- Reset (`notReset` low, asynchronous, takes effect immediately): `out`=0, `outChannel`=0, `outValid`=0, `outWrap`=0, `scanPtr`=0.
- Reset deassertion is honoured on the following rising edge.
- Reset mid-transfer discards the pending sample; no acceptance is reported.
- Latency: input sampled at edge N appears on `out` after edge N, one cycle.
- Throughput: one sample per cycle while `outReady`=1.
- Back-pressure: `outValid`=1 with `outReady`=0 freezes all outputs and `scanPtr`; no samples are lost or skipped.
- Inputs must be stable only around the capturing edge.

## Configuration
- `SEQ_MUX_SCAN_MASK_EN` defined: scan mode honours `mask`.
  - Captured channel = first channel with mask=1 at or after `scanPtr`, circular search.
  - `scanPtr` <= next channel with mask=1 after the captured channel, circular search.
  - `outWrap` uses this next value.
  - If `mask` is all zero, no channel is available: no capture, `scanPtr` holds, and a pending `outValid` clears normally on acceptance.
  - A mask change takes effect on the next capture.
- Not defined: `mask` is ignored; every channel is scanned in order 0..INPUTS-1.

## Test plan
- Reset and default walk:
  - Stimulus: `WIDTH`=8, `INPUTS`=4, in = {0xDD,0xCC,0xBB,0xAA}, hold `notReset` low, then release; `mode`=1, `outReady`=1.
  - Response: `out` sequence AA,BB,CC,DD,AA…; `outChannel` 0,1,2,3,0; `outWrap`=1 only with DD.
- Manual mode:
  - Stimulus: `mode`=0, `sel`=2.
  - Response: `out`=0xCC and `outChannel`=2 every cycle; `scanPtr` unchanged when returning to scan.
- Back-pressure:
  - Stimulus: scan mode, `outReady`=0 for 3 cycles after the BB capture.
  - Response: `out`=0xBB held throughout; after `outReady`=1 the next sample is 0xCC (no skip).
- Enable and async reset:
  - Stimulus: `notEnable`=1 for 2 cycles.
  - Response: no new captures; a pending sample is still accepted once.
  - Stimulus: then pulse `notReset` low between edges.
  - Response: all outputs read 0 immediately.
- Mask, with macro:
  - Stimulus: `mask`=4'b1010.
  - Response: `outChannel` 1,3,1,3; `outWrap`=1 with channel 3.
  - Stimulus: `mask`=0.
  - Response: `outValid` drops after acceptance and stays 0.
- Mask, without macro:
  - Stimulus: same `mask`=4'b1010.
  - Response: channels 0,1,2,3 are all scanned.

Source files
------------

// File: rtl/seq_mux_scanner_if.sv
// seq_mux_scanner_if: groups the control, data and output handshake signals of seq_mux_scanner.
// Ports: master = mux side (drives out/outChannel/outValid/outWrap),
//        slave = producer/consumer side (drives notEnable/mode/sel/in/mask/outReady).
interface seq_mux_scanner_if #(
  parameter int WIDTH  = 8,
  parameter int INPUTS = 4,
  parameter int SEL_W  = 2
);
  logic                    notEnable;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [INPUTS*WIDTH-1:0] in;
  logic [INPUTS-1:0]       mask;
  logic [WIDTH-1:0]        out;
  logic [SEL_W-1:0]        outChannel;
  logic                    outValid;
  logic                    outReady;
  logic                    outWrap;

  modport master (
    input  notEnable, mode, sel, in, mask, outReady,
    output out, outChannel, outValid, outWrap
  );

  modport slave (
    output notEnable, mode, sel, in, mask, outReady,
    input  out, outChannel, outValid, outWrap
  );
endinterface

// File: rtl/seq_mux_scanner.sv
// seq_mux_scanner: registered N-to-1 mux with a round-robin scan sequencer and valid/ready output.
// Latency: one cycle; the word sampled at a capturing edge is on out right after that edge.
// Backpressure: outValid=1 with outReady=0 freezes out/outChannel/outWrap and scanPtr.
// Ports: clock, notReset (async active-low), bus (seq_mux_scanner_if.master).
// Option: define SEQ_MUX_SCAN_MASK_EN to make scan mode skip channels whose mask bit is 0.
module seq_mux_scanner #(
  parameter int WIDTH  = 8,
  parameter int INPUTS = 4,
  parameter int SEL_W  = 2
) (
  input logic                clock,
  input logic                notReset,
  seq_mux_scanner_if.master  bus
);

  logic [SEL_W-1:0] scanPtr;
  logic [SEL_W-1:0] capChan;
  logic [SEL_W-1:0] nextPtr;
  logic             chanAvail;
  logic             doCapture;
  logic             wrapNext;
  logic [WIDTH-1:0] selWord;

  // Channel to capture now and the scan pointer value that follows it.
  always_comb begin : chanSelect
`ifdef SEQ_MUX_SCAN_MASK_EN
    logic [SEL_W-1:0] cand;
    cand = '0;
`endif
    capChan   = bus.sel;
    nextPtr   = scanPtr;
    chanAvail = 1'b1;
    if (bus.mode) begin
`ifdef SEQ_MUX_SCAN_MASK_EN
      chanAvail = |bus.mask;
      capChan   = scanPtr;
      // Walk downwards so the closest enabled channel at/after scanPtr wins.
      for (int i = INPUTS - 1; i >= 0; i--) begin
        cand = scanPtr + SEL_W'(i);
        if (bus.mask[cand]) capChan = cand;
      end
      // Offset INPUTS lands back on capChan: a single enabled channel repeats.
      nextPtr = capChan;
      for (int j = INPUTS; j >= 1; j--) begin
        cand = capChan + SEL_W'(j);
        if (bus.mask[cand]) nextPtr = cand;
      end
`else
      capChan = scanPtr;
      // INPUTS is 2**SEL_W, so natural overflow gives the modulo wrap.
      nextPtr = scanPtr + SEL_W'(1);
`endif
    end
  end

`ifndef SEQ_MUX_SCAN_MASK_EN
  // mask only matters with the masked-scan option.
  logic unusedMask;
  assign unusedMask = ^bus.mask;
`endif

  always_comb begin : wordSelect
    selWord = '0;
    for (int k = 0; k < INPUTS; k++) begin
      if (capChan == SEL_W'(k)) selWord = bus.in[k*WIDTH +: WIDTH];
    end
  end

  // A pending sample being accepted frees the register in the same edge.
  assign doCapture = !bus.notEnable && chanAvail && (!bus.outValid || bus.outReady);
  // Pointer stepping back (or staying) means this sample closes the pass.
  assign wrapNext  = bus.mode && (nextPtr <= capChan);

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      bus.out        <= '0;
      bus.outChannel <= '0;
      bus.outValid   <= 1'b0;
      bus.outWrap    <= 1'b0;
      scanPtr        <= '0;
    end else if (doCapture) begin
      bus.out        <= selWord;
      bus.outChannel <= capChan;
      bus.outValid   <= 1'b1;
      bus.outWrap    <= wrapNext;
      if (bus.mode) scanPtr <= nextPtr;
    end else if (bus.outValid && bus.outReady) begin
      bus.outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_mux_scanner.sv
// tb_seq_mux_scanner: directed checks of reset, scan walk, manual mode, back-pressure,
// enable, asynchronous reset and masked scanning against hand-computed values.
// Ports: none (top-level bench).
module tb_seq_mux_scanner;
  logic clock;
  logic notReset;
  int   nCompared;
  int   nFailed;

  seq_mux_scanner_if #(.WIDTH(8), .INPUTS(4), .SEL_W(2)) bus ();

  seq_mux_scanner #(.WIDTH(8), .INPUTS(4), .SEL_W(2)) dut (
    .clock    (clock),
    .notReset (notReset),
    .bus      (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    notReset      = 1'b0;
    bus.notEnable = 1'b0;
    bus.mode      = 1'b1;
    bus.sel       = 2'd0;
    bus.in        = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    bus.mask      = 4'b1111;
    bus.outReady  = 1'b1;
    tick();
    tick();
    nCompared += 4;
    if (bus.out !== 8'h00) begin nFailed++; $display("FAIL reset_out: got %0h want 00", bus.out); end
    if (bus.outChannel !== 2'd0) begin nFailed++; $display("FAIL reset_chan: got %0d want 0", bus.outChannel); end
    if (bus.outValid !== 1'b0) begin nFailed++; $display("FAIL reset_valid: got %0b want 0", bus.outValid); end
    if (bus.outWrap !== 1'b0) begin nFailed++; $display("FAIL reset_wrap: got %0b want 0", bus.outWrap); end
    notReset = 1'b1;
  endtask

  task automatic test_default_walk();
    logic [1:0] ch;
    logic [7:0] w;
    for (int i = 0; i < 5; i++) begin
      tick();
      ch = 2'(i % 4);
      w  = 8'hAA + 8'h11 * 8'(ch);
      nCompared += 4;
      if (bus.out !== w) begin nFailed++; $display("FAIL walk_out[%0d]: got %0h want %0h", i, bus.out, w); end
      if (bus.outChannel !== ch) begin nFailed++; $display("FAIL walk_chan[%0d]: got %0d want %0d", i, bus.outChannel, ch); end
      if (bus.outValid !== 1'b1) begin nFailed++; $display("FAIL walk_valid[%0d]: got %0b want 1", i, bus.outValid); end
      if (bus.outWrap !== (ch == 2'd3)) begin nFailed++; $display("FAIL walk_wrap[%0d]: got %0b want %0b", i, bus.outWrap, ch == 2'd3); end
    end
  endtask

  task automatic test_manual();
    bus.mode = 1'b0;
    bus.sel  = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      nCompared += 3;
      if (bus.out !== 8'hCC) begin nFailed++; $display("FAIL manual_out[%0d]: got %0h want CC", i, bus.out); end
      if (bus.outChannel !== 2'd2) begin nFailed++; $display("FAIL manual_chan[%0d]: got %0d want 2", i, bus.outChannel); end
      if (bus.outWrap !== 1'b0) begin nFailed++; $display("FAIL manual_wrap[%0d]: got %0b want 0", i, bus.outWrap); end
    end
    // Scan pointer was 1 before manual mode and must resume there.
    bus.mode = 1'b1;
    tick();
    nCompared += 2;
    if (bus.out !== 8'hBB) begin nFailed++; $display("FAIL resume_out: got %0h want BB", bus.out); end
    if (bus.outChannel !== 2'd1) begin nFailed++; $display("FAIL resume_chan: got %0d want 1", bus.outChannel); end
  endtask

  task automatic test_back_pressure();
    bus.outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nCompared += 3;
      if (bus.out !== 8'hBB) begin nFailed++; $display("FAIL bp_out[%0d]: got %0h want BB", i, bus.out); end
      if (bus.outChannel !== 2'd1) begin nFailed++; $display("FAIL bp_chan[%0d]: got %0d want 1", i, bus.outChannel); end
      if (bus.outValid !== 1'b1) begin nFailed++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, bus.outValid); end
    end
    bus.outReady = 1'b1;
    tick();
    nCompared += 2;
    if (bus.out !== 8'hCC) begin nFailed++; $display("FAIL bp_next_out: got %0h want CC", bus.out); end
    if (bus.outChannel !== 2'd2) begin nFailed++; $display("FAIL bp_next_chan: got %0d want 2", bus.outChannel); end
  endtask

  task automatic test_enable();
    bus.notEnable = 1'b1;
    bus.outReady  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      nCompared += 2;
      if (bus.out !== 8'hCC) begin nFailed++; $display("FAIL en_hold_out[%0d]: got %0h want CC", i, bus.out); end
      if (bus.outValid !== 1'b1) begin nFailed++; $display("FAIL en_hold_valid[%0d]: got %0b want 1", i, bus.outValid); end
    end
    bus.outReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      nCompared += 2;
      if (bus.outValid !== 1'b0) begin nFailed++; $display("FAIL en_accept_valid[%0d]: got %0b want 0", i, bus.outValid); end
      if (bus.out !== 8'hCC) begin nFailed++; $display("FAIL en_accept_out[%0d]: got %0h want CC", i, bus.out); end
    end
    bus.notEnable = 1'b0;
    tick();
    nCompared += 3;
    if (bus.out !== 8'hDD) begin nFailed++; $display("FAIL en_resume_out: got %0h want DD", bus.out); end
    if (bus.outChannel !== 2'd3) begin nFailed++; $display("FAIL en_resume_chan: got %0d want 3", bus.outChannel); end
    if (bus.outWrap !== 1'b1) begin nFailed++; $display("FAIL en_resume_wrap: got %0b want 1", bus.outWrap); end
  endtask

  task automatic test_async_reset();
    #2;
    notReset = 1'b0;
    #1;
    nCompared += 4;
    if (bus.out !== 8'h00) begin nFailed++; $display("FAIL areset_out: got %0h want 00", bus.out); end
    if (bus.outChannel !== 2'd0) begin nFailed++; $display("FAIL areset_chan: got %0d want 0", bus.outChannel); end
    if (bus.outValid !== 1'b0) begin nFailed++; $display("FAIL areset_valid: got %0b want 0", bus.outValid); end
    if (bus.outWrap !== 1'b0) begin nFailed++; $display("FAIL areset_wrap: got %0b want 0", bus.outWrap); end
    notReset = 1'b1;
    tick();
    nCompared += 3;
    if (bus.out !== 8'hAA) begin nFailed++; $display("FAIL areset_first_out: got %0h want AA", bus.out); end
    if (bus.outChannel !== 2'd0) begin nFailed++; $display("FAIL areset_first_chan: got %0d want 0", bus.outChannel); end
    if (bus.outValid !== 1'b1) begin nFailed++; $display("FAIL areset_first_valid: got %0b want 1", bus.outValid); end
  endtask

  task automatic test_mask();
    logic [1:0] expCh [4];
    logic       expWr [4];
    logic [7:0] w;
`ifdef SEQ_MUX_SCAN_MASK_EN
    expCh = '{2'd1, 2'd3, 2'd1, 2'd3};
    expWr = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    expCh = '{2'd1, 2'd2, 2'd3, 2'd0};
    expWr = '{1'b0, 1'b0, 1'b1, 1'b0};
`endif
    bus.mask = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      w = 8'hAA + 8'h11 * 8'(expCh[i]);
      nCompared += 3;
      if (bus.outChannel !== expCh[i]) begin nFailed++; $display("FAIL mask_chan[%0d]: got %0d want %0d", i, bus.outChannel, expCh[i]); end
      if (bus.out !== w) begin nFailed++; $display("FAIL mask_out[%0d]: got %0h want %0h", i, bus.out, w); end
      if (bus.outWrap !== expWr[i]) begin nFailed++; $display("FAIL mask_wrap[%0d]: got %0b want %0b", i, bus.outWrap, expWr[i]); end
    end
`ifdef SEQ_MUX_SCAN_MASK_EN
    bus.mask = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      nCompared += 1;
      if (bus.outValid !== 1'b0) begin nFailed++; $display("FAIL mask_empty_valid[%0d]: got %0b want 0", i, bus.outValid); end
    end
`endif
  endtask

  initial begin
    nCompared = 0;
    nFailed   = 0;
    test_reset();
    test_default_walk();
    test_manual();
    test_back_pressure();
    test_enable();
    test_async_reset();
    test_mask();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end
endmodule
